// File: rtl/xload_bus_master.sv
// ============================================================================
// Module   : xload_bus_master
// Function : Byte-stream frame loader driving native-bus word writes.
//            Optional checksum stage enabled by macro XLOAD_CSUM_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module xload_bus_master #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LEN   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;
`ifdef XLOAD_CSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd6;
  localparam logic [2:0] S_TAIL  = S_CSUM;
`else
  localparam logic [2:0] S_TAIL  = S_FIN;
`endif

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [15:0] r_cnt;
  logic [1:0]  r_bcnt;
  logic        w_rdy;
  logic        w_accept;
  logic [15:0] w_len_full;

  assign w_accept   = in_valid && in_ready;
  assign w_len_full = {in_data, r_cnt[15:8]};
  assign in_ready   = w_rdy && !reset;
  assign mem_addr   = {r_addr[31:2], 2'b00};
  assign mem_wdata  = r_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && in_data == SYNC_BYTE) w_next = S_ADDR;
      S_ADDR:  if (w_accept && r_bcnt == 2'd3) w_next = S_LEN;
      S_LEN:   if (w_accept && r_bcnt == 2'd1) w_next = (w_len_full == 16'd0) ? S_TAIL : S_DATA;
      S_DATA:  if (w_accept && r_bcnt == 2'd3) w_next = S_WRITE;
      S_WRITE: if (mem_ready) w_next = (r_cnt == 16'd1) ? S_TAIL : S_DATA;
`ifdef XLOAD_CSUM_EN
      S_CSUM:  if (w_accept) w_next = S_FIN;
`endif
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdy     = 1'b0;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_FIN);
    case (r_state)
      S_IDLE, S_ADDR, S_LEN, S_DATA: w_rdy = 1'b1;
`ifdef XLOAD_CSUM_EN
      S_CSUM: w_rdy = 1'b1;
`endif
      S_WRITE: begin
        mem_valid = 1'b1;
        mem_wstrb = 4'hF;
      end
      default: w_rdy = 1'b0;
    endcase
  end

`ifdef XLOAD_CSUM_EN
  logic [7:0] r_sum;
  logic       r_err;
  assign err = r_err;

  // Running sum covers payload bytes only; header bytes are excluded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum <= 8'h00;
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && w_accept && in_data == SYNC_BYTE) begin
      r_sum <= 8'h00;
      r_err <= 1'b0;
    end else if (r_state == S_DATA && w_accept) begin
      r_sum <= r_sum + in_data;
    end else if (r_state == S_CSUM && w_accept) begin
      r_err <= (in_data != r_sum);
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_cnt   <= 16'h0;
      r_bcnt  <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && in_data == SYNC_BYTE) r_bcnt <= 2'd0;
        end
        S_ADDR: begin
          if (w_accept) begin
            r_addr <= {in_data, r_addr[31:8]};
            r_bcnt <= r_bcnt + 2'd1;
          end
        end
        S_LEN: begin
          if (w_accept) begin
            r_cnt  <= w_len_full;
            r_bcnt <= (r_bcnt == 2'd1) ? 2'd0 : r_bcnt + 2'd1;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_wdata <= {in_data, r_wdata[31:8]};
            r_bcnt  <= r_bcnt + 2'd1;
          end
        end
        S_WRITE: begin
          // Low address bits never reach the bus, so a plain +4 wraps correctly.
          if (mem_ready) begin
            r_addr <= r_addr + 32'd4;
            r_cnt  <= r_cnt - 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_xload_bus_master.sv
// ============================================================================
// Module   : tb_xload_bus_master
// Function : Scoreboard bench for xload_bus_master (honours XLOAD_CSUM_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_xload_bus_master;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  bit slow = 0;
  int wcnt = 0;
  logic [63:0] exp_q[$];
  logic [31:0] payload[$];

  xload_bus_master #(.SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Responder: immediate completion, or five wait cycles per write when slow.
  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!slow) mem_ready = 1'b1;
      else if (mem_valid) begin
        if (wcnt >= 5) mem_ready = 1'b1;
        else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin
    bit          hold_v;
    bit          prev_done;
    logic [31:0] hold_a;
    logic [31:0] hold_d;
    logic [63:0] e;
    hold_v = 0;
    prev_done = 0;
    hold_a = '0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (done) begin
        check("done_width", {63'd0, prev_done}, 64'd0);
        done_cnt++;
      end
      prev_done = done;
      if (mem_valid) begin
        check("in_ready_in_write", {63'd0, in_ready}, 64'd0);
        check("wstrb", {60'd0, mem_wstrb}, 64'hF);
        if (hold_v) begin
          check("addr_stable", {32'd0, mem_addr}, {32'd0, hold_a});
          check("data_stable", {32'd0, mem_wdata}, {32'd0, hold_d});
        end
        if (mem_ready) begin
          hold_v = 0;
          if (exp_q.size() == 0) check("unexpected_write", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            check("wr_addr", {32'd0, mem_addr}, {32'd0, e[63:32]});
            check("wr_data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
          end
        end else begin
          hold_v = 1;
          hold_a = mem_addr;
          hold_d = mem_wdata;
        end
      end else begin
        hold_v = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 100) begin
        check("in_ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [15:0] n, input bit bad);
    logic [7:0]  s;
    logic [31:0] w;
    logic [31:0] ea;
    s = 8'h00;
    send_byte(8'hA5);
    @(negedge clk);
    check("err_clear_on_sync", {63'd0, err}, 64'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int k = 0; k < int'(n); k++) begin
      w  = payload[k];
      ea = {a[31:2], 2'b00} + 32'(4 * k);
      exp_q.push_back({ea, w});
      for (int j = 0; j < 4; j++) begin
        send_byte(w[8*j +: 8]);
        s = s + w[8*j +: 8];
      end
    end
`ifdef XLOAD_CSUM_EN
    send_byte(bad ? s + 8'd1 : s);
`endif
  endtask

  task automatic run_frame(input string tag, input logic [31:0] a, input logic [15:0] n,
                           input bit bad);
    int  d0;
    bit  seen;
    logic exp_err;
    d0 = done_cnt;
    seen = 0;
`ifdef XLOAD_CSUM_EN
    exp_err = bad;
`else
    exp_err = 1'b0;
`endif
    send_frame(a, n, bad);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (done_cnt > d0) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check({tag, "_done_timeout"}, 64'd0, 64'd1);
    check({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
    @(negedge clk);
    check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_busy_idle"}, {63'd0, busy}, 64'd0);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("rst_addr", {32'd0, mem_addr}, 64'd0);
    check("rst_wdata", {32'd0, mem_wdata}, 64'd0);
    check("rst_wstrb", {60'd0, mem_wstrb}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    payload = '{32'h44332211, 32'h88776655};
    run_frame("basic", 32'h00000100, 16'd2, 1'b0);
    run_frame("bad_csum", 32'h00000100, 16'd2, 1'b1);
    run_frame("after_bad", 32'h00000100, 16'd2, 1'b0);

    // Sync values inside address and data must be taken as payload.
    slow = 1;
    payload = '{32'hA5A500A5, 32'h12345678, 32'hDEADBEEF};
    run_frame("slow", 32'h000002A5, 16'd3, 1'b0);
    slow = 0;

    send_byte(8'h00);
    send_byte(8'hFF);
    payload = '{32'hCAFEF00D, 32'h0BADC0DE};
    run_frame("wrap", 32'hFFFFFFFE, 16'd2, 1'b0);

    run_frame("len0", 32'h00001000, 16'd0, 1'b0);

    send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_mem_valid", {63'd0, mem_valid}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    repeat (20) @(posedge clk);
    #1;
    payload = '{32'h04030201};
    run_frame("after_rst", 32'h00003000, 16'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
